// File: rtl/serial_parity_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_parity_tx
// Description : EN/I serial transmitter. Sends a word LSB-first, then a parity
//               bit, then a mandatory one-cycle EN-low gap. Optional macro
//               SERIAL_PARITY_TX_ERR_INJ_EN adds INJ to invert one frame's parity.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_parity_tx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              LOAD,
`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
  input  logic              INJ,
`endif
  input  logic [DATA_W-1:0] D,
  output logic              READY,
  output logic              EN,
  output logic              I,
  output logic              DONE
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              par, par_nx;
  logic              ready_nx, en_nx, i_nx, done_nx;
  logic              inj_bit;

`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
  assign inj_bit = INJ;
`else
  assign inj_bit = 1'b0;
`endif

  // Outputs are computed for the next state and registered, so shreg holds
  // the bits still to be sent after the one currently on I.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    par_nx   = par;
    ready_nx = 1'b0;
    en_nx    = 1'b0;
    i_nx     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD) begin
          state_nx = DATA;
          shreg_nx = D >> 1;
          cnt_nx   = '0;
          par_nx   = (^D) ^ PARITY_ODD ^ inj_bit;
          en_nx    = 1'b1;
          i_nx     = D[0];
        end else begin
          ready_nx = 1'b1;
        end
      end
      DATA: begin
        shreg_nx = shreg >> 1;
        cnt_nx   = cnt + CNT_W'(1);
        en_nx    = 1'b1;
        if (cnt == LAST_BIT) begin
          state_nx = PAR;
          i_nx     = par;
        end else begin
          i_nx     = shreg[0];
        end
      end
      PAR: begin
        state_nx = GAP;
        done_nx  = 1'b1;
      end
      GAP: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        shreg_nx = '0;
        cnt_nx   = '0;
        par_nx   = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      READY <= 1'b1;
      EN    <= 1'b0;
      I     <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
      par   <= par_nx;
      READY <= ready_nx;
      EN    <= en_nx;
      I     <= i_nx;
      DONE  <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_tx.sv
`default_nettype none
// Testbench for serial_parity_tx: even and odd parity instances share stimulus;
// a frame-level model feeds a scoreboard drained by a bit-collecting monitor.
module tb_serial_parity_tx;

  localparam int DATA_W = 8;
`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  typedef struct packed {
    logic              inj;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b1;
  logic              LOAD = 1'b0;
  logic              inj_s = 1'b0;
  logic [DATA_W-1:0] D = '0;
  logic [1:0]        ready_w, en_w, i_w, done_w;

  exp_t expq[$];
  int   busy = 0;
  int   acc_cnt = 0;
  int   passed = 0;
  int   total = 0;
  int   bitcnt[2];
  logic [DATA_W:0] fr[2];

  always #5 CLK = ~CLK;

  serial_parity_tx #(.DATA_W(DATA_W), .PARITY_ODD(1'b0)) dut_even (
    .CLK(CLK), .RSTN(RSTN), .LOAD(LOAD),
`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
    .INJ(inj_s),
`endif
    .D(D), .READY(ready_w[0]), .EN(en_w[0]), .I(i_w[0]), .DONE(done_w[0])
  );

  serial_parity_tx #(.DATA_W(DATA_W), .PARITY_ODD(1'b1)) dut_odd (
    .CLK(CLK), .RSTN(RSTN), .LOAD(LOAD),
`ifdef SERIAL_PARITY_TX_ERR_INJ_EN
    .INJ(inj_s),
`endif
    .D(D), .READY(ready_w[1]), .EN(en_w[1]), .I(i_w[1]), .DONE(done_w[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Frame-level model: a frame is accepted whenever the link is free and LOAD
  // is high, and then occupies DATA_W data + 1 parity + 1 gap cycles.
  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      busy <= 0;
      expq.delete();
    end else if (busy == 0) begin
      if (LOAD) begin
        expq.push_back('{inj: inj_s & INJ_ON, d: D});
        busy    <= DATA_W + 2;
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      busy <= busy - 1;
    end
  end

  // Monitor: per-cycle handshake checks plus frame reassembly and scoreboard.
  always @(negedge CLK) begin
    logic frame_done;
    exp_t e;
    logic exp_par;
    frame_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready[%0d]", k), 32'(ready_w[k]), 32'(busy == 0));
      chk($sformatf("en[%0d]", k),    32'(en_w[k]),    32'(busy >= 2));
      chk($sformatf("done[%0d]", k),  32'(done_w[k]),  32'(busy == 1));
      if (busy < 2) chk($sformatf("i_idle[%0d]", k), 32'(i_w[k]), 32'd0);
      if (!RSTN) begin
        bitcnt[k] = 0;
      end else if (en_w[k]) begin
        fr[k][bitcnt[k]] = i_w[k];
        bitcnt[k]++;
        if (bitcnt[k] == DATA_W + 1) begin
          bitcnt[k]  = 0;
          frame_done = 1'b1;
          if (expq.size() == 0) begin
            chk($sformatf("frame_expected[%0d]", k), 32'd0, 32'd1);
          end else begin
            e = expq[0];
            exp_par = ($countones(e.d) % 2 == 1) ^ (k == 1) ^ e.inj;
            chk($sformatf("data[%0d]", k), 32'(fr[k][DATA_W-1:0]), 32'(e.d));
            chk($sformatf("parity[%0d]", k), 32'(fr[k][DATA_W]), 32'(exp_par));
          end
        end
      end
    end
    if (frame_done && expq.size() > 0) void'(expq.pop_front());
  end

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic inj);
    int start;
    int n;
    start = acc_cnt;
    n     = 0;
    D     = d;
    inj_s = inj;
    LOAD  = 1'b1;
    while (acc_cnt == start && n < 4 * DATA_W) begin
      @(negedge CLK);
      n++;
    end
    chk("accept", 32'(acc_cnt != start), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bitcnt[0] = 0;
    bitcnt[1] = 0;
    #1 RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (20) @(negedge CLK);
    chk("idle_ready", 32'(ready_w), 32'h3);
    chk("idle_en", 32'(en_w), 32'h0);

    // Basic frames: even/odd parity on 0xA5, single set bit.
    send_frame(8'hA5, 1'b0);
    LOAD = 1'b0;
    repeat (2) @(negedge CLK);
    send_frame(8'h01, 1'b0);
    LOAD = 1'b0;
    repeat (12) @(negedge CLK);

    // LOAD held high; D changes while busy.
    send_frame(8'hFF, 1'b0);
    repeat (3) @(negedge CLK);
    send_frame(8'h00, 1'b0);
    LOAD = 1'b0;
    repeat (12) @(negedge CLK);

    // Asynchronous reset during the fourth data bit.
    send_frame(8'h3C, 1'b0);
    LOAD = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("rst_en", 32'(en_w), 32'h0);
    chk("rst_i", 32'(i_w), 32'h0);
    chk("rst_ready", 32'(ready_w), 32'h3);
    chk("rst_done", 32'(done_w), 32'h0);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    send_frame(8'h3C, 1'b0);
    LOAD = 1'b0;
    repeat (12) @(negedge CLK);

    // Parity injection for one frame, then a clean frame.
    send_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b0);
    LOAD = 1'b0;
    repeat (12) @(negedge CLK);

    // Random words, injection and idle gaps (0 = LOAD held high).
    for (int f = 0; f < 30; f++) begin
      int gap;
      send_frame(DATA_W'($urandom), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        LOAD = 1'b0;
        repeat (DATA_W + gap) @(negedge CLK);
      end
    end
    LOAD = 1'b0;
    repeat (DATA_W + 6) @(negedge CLK);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    chk("monitor_idle", 32'(bitcnt[0] + bitcnt[1]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
